// File: rtl/control_seq_pkg.sv
// Shared definitions for the kanade32 multicycle sequencer: state encodings,
// default debug-state width and the wait-counter sizing helper.
package control_seq_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT       = 4'd0,
    ST_FETCH      = 4'd1,
    ST_FETCH_WAIT = 4'd2,
    ST_DECODE     = 4'd3,
    ST_EXECUTE    = 4'd4,
    ST_MEM        = 4'd5,
    ST_MEM_WAIT   = 4'd6,
    ST_WB         = 4'd7,
    ST_HALT       = 4'd8,
    ST_FAULT      = 4'd9
  } state_t;

  // Largest of three latency/limit parameters; sizes the shared wait counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // FETCH_WAIT and MEM_WAIT are the only states that stall on the RAM.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH_WAIT) || (s == ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/control_seq_wait_timer.sv
// Loadable down-counter shared by the fetch and memory wait states.
// Decrements saturate at zero; zero flags that the minimum latency has elapsed.
module control_seq_wait_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/control_seq.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the kanade32 core.
// Optional wait-state timeout with sticky FAULT: define CTRL_MEM_TIMEOUT_EN.
module control_seq #(
  parameter int FETCH_LAT      = 1,
  parameter int MEM_LAT        = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int STATE_W        = control_seq_pkg::STATE_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mem_ready,
  input  logic               ins_mem_access,
  input  logic               ins_reg_write,
  input  logic               halt_req,
  output logic               pc_wren,
  output logic               ram_addr_src,
  output logic               fd_wren,
  output logic               de_wren,
  output logic               em_wren,
  output logic               mw_wren,
  output logic               mw_mem_wren,
  output logic               reg_wren,
  output logic               halted,
  output logic               fault,
  output logic [STATE_W-1:0] state_o
);

  import control_seq_pkg::*;

  localparam int CNT_W = $clog2(max3(FETCH_LAT, MEM_LAT, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] FETCH_LOAD = CNT_W'(FETCH_LAT - 1);
  localparam logic [CNT_W-1:0] MEM_LOAD   = CNT_W'(MEM_LAT - 1);

  state_t state_reg, state_next;
  logic   is_mem_reg, is_wr_reg;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_dec;
  logic             tmr_zero;
  logic             wait_timeout;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Instruction class is captured once in EXECUTE and held through WB.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      is_mem_reg <= 1'b0;
      is_wr_reg  <= 1'b0;
    end else if (state_reg == ST_EXECUTE) begin
      is_mem_reg <= ins_mem_access;
      is_wr_reg  <= ins_reg_write;
    end
  end

  control_seq_wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] to_cnt_reg;

  // Wait states never follow one another, so clearing outside them is the
  // same as clearing on entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      to_cnt_reg <= '0;
    end else if (!is_wait_state(state_reg)) begin
      to_cnt_reg <= '0;
    end else if (to_cnt_reg != TO_MAX) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  // The count reaches TIMEOUT_CYCLES on the clock that ends this cycle.
  assign wait_timeout = (to_cnt_reg == TO_LAST);
`else
  assign wait_timeout = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    pc_wren      = 1'b0;
    ram_addr_src = 1'b0;
    fd_wren      = 1'b0;
    de_wren      = 1'b0;
    em_wren      = 1'b0;
    mw_wren      = 1'b0;
    mw_mem_wren  = 1'b0;
    reg_wren     = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;

    case (state_reg)
      ST_INIT: begin
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        tmr_load     = 1'b1;
        tmr_load_val = FETCH_LOAD;
        state_next   = ST_FETCH_WAIT;
      end

      ST_FETCH_WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_zero && mem_ready) begin
          fd_wren    = 1'b1;
          state_next = ST_DECODE;
        end else if (wait_timeout) begin
          state_next = ST_FAULT;
        end
      end

      ST_DECODE: begin
        de_wren    = 1'b1;
        state_next = ST_EXECUTE;
      end

      // Non-memory instructions skip MEM and pass straight through MEM_WAIT.
      ST_EXECUTE: begin
        em_wren = 1'b1;
        if (ins_mem_access) begin
          state_next = ST_MEM;
        end else begin
          tmr_load     = 1'b1;
          tmr_load_val = '0;
          state_next   = ST_MEM_WAIT;
        end
      end

      ST_MEM: begin
        ram_addr_src = 1'b1;
        tmr_load     = 1'b1;
        tmr_load_val = MEM_LOAD;
        state_next   = ST_MEM_WAIT;
      end

      ST_MEM_WAIT: begin
        ram_addr_src = is_mem_reg;
        tmr_dec      = 1'b1;
        if (tmr_zero && (mem_ready || !is_mem_reg)) begin
          mw_wren     = 1'b1;
          pc_wren     = 1'b1;
          mw_mem_wren = is_mem_reg;
          state_next  = ST_WB;
        end else if (wait_timeout) begin
          state_next = ST_FAULT;
        end
      end

      ST_WB: begin
        reg_wren   = is_wr_reg;
        state_next = halt_req ? ST_HALT : ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
        if (!halt_req) begin
          state_next = ST_FETCH;
        end
      end

`ifdef CTRL_MEM_TIMEOUT_EN
      ST_FAULT: begin
        fault = 1'b1;
      end
`endif

      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  assign state_o = STATE_W'(state_reg);

endmodule

// File: tb/tb_control_seq.sv
// Randomized bench for control_seq: an instruction-level timeline model
// predicts every output on every cycle from the ready/halt/decode inputs.
module tb_control_seq;
  import control_seq_pkg::*;

  localparam int FL = 3;
  localparam int ML = 2;
  localparam int TO = 8;
  localparam int SW = 4;
  localparam int NC = 600;

  localparam int B_PC  = 9;
  localparam int B_RAS = 8;
  localparam int B_FD  = 7;
  localparam int B_DE  = 6;
  localparam int B_EM  = 5;
  localparam int B_MW  = 4;
  localparam int B_MWM = 3;
  localparam int B_REG = 2;
  localparam int B_HLT = 1;
  localparam int B_FLT = 0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mem_ready = 1'b0;
  logic ins_mem_access = 1'b0;
  logic ins_reg_write = 1'b0;
  logic halt_req = 1'b0;
  logic pc_wren, ram_addr_src, fd_wren, de_wren, em_wren;
  logic mw_wren, mw_mem_wren, reg_wren, halted, fault;
  logic [SW-1:0] state_o;
  logic [9:0] obs;

  int checks = 0;
  int errors = 0;

  bit rdy[NC];
  bit hlt[NC];
  bit im[NC];
  bit iw[NC];
  logic [9:0] exp_v[NC];

  always #5 clk = ~clk;

  control_seq #(
    .FETCH_LAT      (FL),
    .MEM_LAT        (ML),
    .TIMEOUT_CYCLES (TO),
    .STATE_W        (SW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_ready      (mem_ready),
    .ins_mem_access (ins_mem_access),
    .ins_reg_write  (ins_reg_write),
    .halt_req       (halt_req),
    .pc_wren        (pc_wren),
    .ram_addr_src   (ram_addr_src),
    .fd_wren        (fd_wren),
    .de_wren        (de_wren),
    .em_wren        (em_wren),
    .mw_wren        (mw_wren),
    .mw_mem_wren    (mw_mem_wren),
    .reg_wren       (reg_wren),
    .halted         (halted),
    .fault          (fault),
    .state_o        (state_o)
  );

  assign obs = {pc_wren, ram_addr_src, fd_wren, de_wren, em_wren,
                mw_wren, mw_mem_wren, reg_wren, halted, fault};

  // Stall runs are capped at 3 so random traffic never nears the timeout.
  task automatic gen_stimulus(input int nc);
    int run = 0;
    for (int c = 0; c < nc; c++) begin
      rdy[c] = (run >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
      run    = rdy[c] ? 0 : run + 1;
      hlt[c] = ($urandom_range(0, 3) == 0);
      im[c]  = 1'($urandom_range(0, 1));
      iw[c]  = 1'($urandom_range(0, 1));
    end
  endtask

  // Walks instruction by instruction: each phase ends at the first cycle where
  // its minimum latency has passed and the RAM is ready (cycle 0 is INIT).
  task automatic build_model(input int nc);
    int c, f, e, d, wb, h;
    bit m, w;
    for (int k = 0; k < nc; k++) exp_v[k] = '0;
    c = 1;
    while (c < nc) begin
      f = c + FL;
      while (f < nc && !rdy[f]) f++;
      if (f >= nc) break;
      exp_v[f][B_FD] = 1'b1;
      if (f + 1 < nc) exp_v[f + 1][B_DE] = 1'b1;
      e = f + 2;
      if (e >= nc) break;
      exp_v[e][B_EM] = 1'b1;
      m = im[e];
      w = iw[e];
      if (m) begin
        d = e + 1 + ML;
        while (d < nc && !rdy[d]) d++;
        for (int k = e + 1; k <= d && k < nc; k++) exp_v[k][B_RAS] = 1'b1;
      end else begin
        d = e + 1;
      end
      if (d >= nc) break;
      exp_v[d][B_PC]  = 1'b1;
      exp_v[d][B_MW]  = 1'b1;
      exp_v[d][B_MWM] = m;
      wb = d + 1;
      if (wb >= nc) break;
      exp_v[wb][B_REG] = w;
      if (hlt[wb]) begin
        h = wb + 1;
        while (h < nc && hlt[h]) h++;
        for (int k = wb + 1; k <= h && k < nc; k++) exp_v[k][B_HLT] = 1'b1;
        c = h + 1;
      end else begin
        c = wb + 1;
      end
    end
  endtask

  // Entered at a falling edge with reset_n low; releases reset in cycle 0.
  task automatic run_random(input int nc, input string tag);
    gen_stimulus(nc);
    build_model(nc);
    for (int c = 0; c < nc; c++) begin
      if (c > 0) @(negedge clk);
      reset_n        = 1'b1;
      mem_ready      = rdy[c];
      halt_req       = hlt[c];
      ins_mem_access = im[c];
      ins_reg_write  = iw[c];
      #1;
      checks++;
      if (obs !== exp_v[c]) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs %b, expected %b", tag, c, obs, exp_v[c]);
      end
      if (exp_v[c][B_PC])
        $display("%s: retire at cycle %0d mem=%0d", tag, c, exp_v[c][B_MWM]);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 10'b0 || state_o !== ST_INIT) begin
      errors++;
      $display("FAIL reset: outputs %b state %0d, expected 0 and INIT", obs, state_o);
    end
    $display("reset: outputs %b state %0d", obs, state_o);
  endtask

  task automatic test_random;
    run_random(NC, "random");
  endtask

  task automatic test_reset_mid_mem;
    bit found = 1'b0;
    @(negedge clk);
    halt_req       = 1'b0;
    ins_mem_access = 1'b1;
    ins_reg_write  = 1'b1;
    mem_ready      = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      #1;
      if (state_o == ST_MEM_WAIT) found = 1'b1;
      else begin
        mem_ready = (state_o != ST_MEM);
        @(negedge clk);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_mem_wait: state %0d, expected MEM_WAIT within 60 cycles", state_o);
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 10'b0 || state_o !== ST_INIT) begin
      errors++;
      $display("FAIL reset_in_mem_wait: outputs %b state %0d, expected 0 and INIT", obs, state_o);
    end
    $display("reset in MEM_WAIT: outputs %b state %0d", obs, state_o);
    @(negedge clk);
    run_random(200, "after_reset");
  endtask

  // RAM never answers the first fetch until cycle 20.
  task automatic test_stall;
    logic [9:0] exp;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    mem_ready      = 1'b0;
    halt_req       = 1'b0;
    ins_mem_access = 1'b0;
    ins_reg_write  = 1'b0;
    reset_n        = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      mem_ready = (c >= 20);
      #1;
      exp = '0;
`ifdef CTRL_MEM_TIMEOUT_EN
      if (c >= 2 + TO) exp[B_FLT] = 1'b1;
`else
      if (c == 20) exp[B_FD] = 1'b1;
      if (c == 21) exp[B_DE] = 1'b1;
      if (c == 22) exp[B_EM] = 1'b1;
`endif
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stall cycle %0d: outputs %b, expected %b", c, obs, exp);
      end
    end
    $display("stall: outputs %b at end of stall window", obs);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL stall_reset: outputs %b, expected 0", obs);
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_reset_mid_mem();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
